// File: rtl/rr_decode_arbiter_pkg.sv
// Shared constants, state encoding and sizing helper for the round-robin
// decoder arbiter.
package rr_decode_arbiter_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  // Hold counter width: clog2(max_hold+1), never narrower than one bit.
  function automatic int unsigned hold_w(input int unsigned max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_pick.sv
// Combinational round-robin pick: first set request at or after ptr, mod 16.
module rr_pick
  import rr_decode_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    any = |rot;
    off = '0;
    // Descending scan so the lowest set bit of the rotated vector wins.
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) off = IDX_W'(i - 1);
    end
    idx = off + ptr;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving the select/enable of a shared 4-to-16 decoder,
// with a hold limit and one dead cycle between consecutive grants.
module rr_decode_arbiter
  import rr_decode_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arb_en,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] sel,
  output logic             en,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned HC_W = hold_w(MAX_HOLD);

  state_e           state_q;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] ptr_q;
  logic [HC_W-1:0]  hold_q;
  logic             en_q;
  logic             busy_q;
  logic             tmo_q;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             release_hit;
  logic             hold_hit;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign release_hit = ~req[sel_q];
  assign hold_hit    = (MAX_HOLD != 0) && (hold_q == HC_W'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        ST_GRANT: begin
          if (release_hit || hold_hit) begin
            state_q <= ST_GAP;
            en_q    <= 1'b0;
            ptr_q   <= sel_q + 1'b1;
            tmo_q   <= ~release_hit;
          end else if (hold_q != '1) begin
            hold_q  <= hold_q + 1'b1;
          end
        end
        // IDLE, GAP and the unused encoding share the launch decision.
        default: begin
          if (arb_en && pick_any) begin
            state_q <= ST_GRANT;
            sel_q   <= pick_idx;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            hold_q  <= HC_W'(1);
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign sel     = sel_q;
  assign en      = en_q;
  assign busy    = busy_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: directed scenarios plus random
// traffic compared each cycle against a behavioural model.
module tb_rr_decode_arbiter;

  localparam int unsigned MAX_HOLD = 8;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        arb_en = 1'b0;
  logic [15:0] req    = '0;
  logic [3:0]  sel;
  logic        en;
  logic        busy;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  // Model: 0 = idle, 1 = granting, 2 = dead cycle.
  int m_state, m_sel, m_ptr, m_hold, m_to;

  always #5 clk = ~clk;

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_en  (arb_en),
    .req     (req),
    .sel     (sel),
    .en      (en),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      int i;
      i = (p + k) % 16;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_sel = 0; m_ptr = 0; m_hold = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [15:0] r, input logic a);
    int w;
    w    = pick(r, m_ptr);
    m_to = 0;
    if (m_state == 1) begin
      if (!r[m_sel]) begin
        m_state = 2;
        m_ptr   = (m_sel + 1) % 16;
      end else if (MAX_HOLD != 0 && m_hold == int'(MAX_HOLD)) begin
        m_state = 2;
        m_ptr   = (m_sel + 1) % 16;
        m_to    = 1;
      end else begin
        m_hold++;
      end
    end else if (a && w >= 0) begin
      m_state = 1;
      m_sel   = w;
      m_hold  = 1;
    end else begin
      m_state = 0;
    end
  endtask

  task automatic compare_all();
    check("sel",     32'(sel),     32'(m_sel));
    check("en",      32'(en),      32'(m_state == 1));
    check("busy",    32'(busy),    32'(m_state != 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  // Called at a falling edge; drives inputs, steps the model on the rising edge.
  task automatic cyc(input logic [15:0] r, input logic a);
    req    = r;
    arb_en = a;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(r, a);
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("rst_async_en",  32'(en),   32'(0));
    check("rst_async_sel", 32'(sel),  32'(0));
    check("rst_async_bsy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          seq[$];
  int          exp_seq[4] = '{0, 15, 0, 15};
  logic        prev_en;
  logic [15:0] r;
  int          tmo_cnt;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_sel",  32'(sel),     32'(0));
    check("rst_en",   32'(en),      32'(0));
    check("rst_busy", 32'(busy),    32'(0));
    check("rst_tmo",  32'(timeout), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, grant then release
    cyc(16'h0001, 1'b1);
    check("t1_en", 32'(en), 32'(1));
    check("t1_sel", 32'(sel), 32'(0));
    cyc(16'h0001, 1'b1);
    cyc(16'h0000, 1'b1);
    check("t1_gap_en", 32'(en), 32'(0));
    check("t1_gap_busy", 32'(busy), 32'(1));
    cyc(16'h0000, 1'b1);
    check("t1_idle_busy", 32'(busy), 32'(0));

    // Two requesters, each releasing after two granted cycles
    rst_pulse();
    prev_en = en;
    for (int c = 0; c < 24; c++) begin
      r = 16'h8001;
      if (m_state == 1 && m_hold >= 2) r[m_sel] = 1'b0;
      cyc(r, 1'b1);
      if (en && !prev_en) seq.push_back(int'(sel));
      prev_en = en;
    end
    check("t2_grants", 32'(seq.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++)
      if (i < seq.size()) check($sformatf("t2_sel%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // Stuck requester hits the hold limit repeatedly
    cyc(16'h0000, 1'b1);
    cyc(16'h0000, 1'b1);
    tmo_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cyc(16'h0020, 1'b1);
      if (timeout) tmo_cnt++;
    end
    check("t3_tmo_cnt", 32'(tmo_cnt), 32'(3));

    // Pointer-relative priority: 9 beats 3 from ptr=4, then 3 from ptr=10
    cyc(16'h0000, 1'b1);
    cyc(16'h0000, 1'b1);
    cyc(16'h0008, 1'b1);
    cyc(16'h0000, 1'b1);
    cyc(16'h0208, 1'b1);
    check("t4_first", 32'(sel), 32'(9));
    cyc(16'h0008, 1'b1);
    cyc(16'h0008, 1'b1);
    check("t4_second", 32'(sel), 32'(3));
    check("t4_en", 32'(en), 32'(1));

    // arb_en low does not cut a grant and blocks new ones
    cyc(16'h0000, 1'b1);
    cyc(16'h0000, 1'b1);
    cyc(16'h0080, 1'b1);
    repeat (3) cyc(16'h0080, 1'b0);
    check("t5_hold_en", 32'(en), 32'(1));
    check("t5_hold_sel", 32'(sel), 32'(7));
    cyc(16'hFF7F, 1'b0);
    repeat (4) cyc(16'hFFFF, 1'b0);
    check("t5_no_grant", 32'(en), 32'(0));
    check("t5_idle", 32'(busy), 32'(0));

    // Asynchronous reset during a grant, then resume from ptr=0
    cyc(16'h1000, 1'b1);
    cyc(16'h1000, 1'b1);
    check("t6_pre_sel", 32'(sel), 32'(12));
    rst_pulse();
    cyc(16'h1000, 1'b1);
    check("t6_post_sel", 32'(sel), 32'(12));
    check("t6_post_en", 32'(en), 32'(1));

    // Random traffic
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 499) == 0) rst_pulse();
      cyc(r, $urandom_range(0, 7) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
